// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between the AES inverse key scheduler and its consumer.
//
// Valid/ready contract:
//   rk_valid rises once round key 10 is available. rk and rk_idx are
//   guaranteed stable while rk_valid && !rk_ready. A key transfers on
//   every rising clock edge where rk_valid && rk_ready are both high.
//   rk_valid never depends combinationally on rk_ready.
//   start is a one-cycle request; key_in is sampled on that same edge.
//   done pulses for one cycle after round key 0 has transferred.
interface aes_inv_key_sched_if;
  logic         start;
  logic [0:127] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [0:127] rk;
  logic [3:0]   rk_idx;
  logic         done;

  // Consumer / controller side
  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk, rk_idx, done
  );

  // Key scheduler side
  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk, rk_idx, done
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Sequential AES-128 round-key generator for decryption.
// Runs the forward schedule to round key 10 (one round per clock), then
// walks it backward one round per handshake, so keys come out 10,9,...,0.
// Only the current 128-bit round key is ever stored.
// Bit order: [0:127], word0 = bits [0:31], big-endian bytes.
module aes_inv_key_sched #(
  // 0: key_in is the cipher key; 1: key_in is already round key 10
  parameter bit SKIP_FWD = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  aes_inv_key_sched_if.slave  bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   r;
  logic [0:127] rk_q;
  logic         busy_q;
  logic         valid_q;
  logic         done_q;

  // ---------------------------------------------------------------------
  // GF(2^8) helpers; the S-box is computed as the field inverse followed
  // by the AES affine transform rather than stored as a table.
  // ---------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 = a^(2+4+...+128); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b
         ^ {b[6:0], b[7]}
         ^ {b[5:0], b[7:6]}
         ^ {b[4:0], b[7:5]}
         ^ {b[3:0], b[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for rounds 1..10; other indices never reach the datapath
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // ---------------------------------------------------------------------
  // Shared round datapath
  // ---------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p1, p2, p3;
  logic [31:0]  sub_in, sub_out;
  logic [3:0]   rcon_idx;
  logic [31:0]  rcon_word;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  b0;
  logic [0:127] fwd_key;
  logic [0:127] bwd_key;

  // Forward and backward round keys from the stored key; one S-box bank
  // serves both since only one direction is active in any state.
  always_comb begin
    w0 = rk_q[0:31];
    w1 = rk_q[32:63];
    w2 = rk_q[64:95];
    w3 = rk_q[96:127];

    // Undo the XOR chain to recover words 1..3 of the previous round
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;

    // Forward uses Rcon[r+1] on RotWord(w3); backward uses Rcon[r] on RotWord(p3)
    sub_in   = (state == S_EMIT) ? rot_word(p3) : rot_word(w3);
    rcon_idx = (state == S_EMIT) ? r : r + 4'd1;

    sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                 sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    rcon_word = {rcon(rcon_idx), 24'h000000};

    f0 = w0 ^ sub_out ^ rcon_word;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;

    b0 = w0 ^ sub_out ^ rcon_word;

    fwd_key = {f0, f1, f2, f3};
    bwd_key = {b0, p1, p2, p3};
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  // Sequences IDLE -> FWD -> EMIT -> IDLE and owns the key register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      r       <= 4'd0;
      rk_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // The done-pulse cycle is still the tail of the previous run,
          // so a start landing on it is dropped.
          if (bus.start && !done_q) begin
            rk_q   <= bus.key_in;
            busy_q <= 1'b1;
            if (SKIP_FWD) begin
              r       <= 4'd10;
              valid_q <= 1'b1;
              state   <= S_EMIT;
            end else begin
              r     <= 4'd0;
              state <= S_FWD;
            end
          end
        end

        S_FWD: begin
          rk_q <= fwd_key;
          r    <= r + 4'd1;
          if (r == 4'd9) begin
            valid_q <= 1'b1;
            state   <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (bus.rk_ready) begin
            if (r != 4'd0) begin
              rk_q <= bwd_key;
              r    <= r - 4'd1;
            end else begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= S_IDLE;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rk       = rk_q;
  assign bus.rk_idx   = r;
  assign bus.rk_valid = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: FIPS-197 directed vectors plus random keys
// against a table-driven full key expansion, random backpressure, reset
// abort and ignored start requests. Both SKIP_FWD variants are exercised.
module tb_aes_inv_key_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_key_sched_if if0 ();
  aes_inv_key_sched_if if1 ();
  logic [1:0] dbg0, dbg1;

  aes_inv_key_sched #(.SKIP_FWD(1'b0)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (if0),
    .dbg_state (dbg0)
  );

  aes_inv_key_sched #(.SKIP_FWD(1'b1)) u_skip (
    .clk       (clk),
    .rst       (rst),
    .bus       (if1),
    .dbg_state (dbg1)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_RK9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [127:0] model_rk [0:10];
  logic [127:0] got_rk   [0:10];

  // Observation mux selecting which DUT a run looks at
  bit           sel;
  logic         o_valid, o_busy, o_done;
  logic [127:0] o_rk;
  logic [3:0]   o_idx;

  always_comb begin
    if (sel) begin
      o_valid = if1.rk_valid; o_busy = if1.busy; o_done = if1.done;
      o_rk    = if1.rk;       o_idx  = if1.rk_idx;
    end else begin
      o_valid = if0.rk_valid; o_busy = if0.busy; o_done = if0.done;
      o_rk    = if0.rk;       o_idx  = if0.rk_idx;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_sbox(input logic [7:0] a);
    logic [0:2047] t;
    t = SBOX;
    return t[8*a +: 8];
  endfunction

  // Textbook AES-128 key expansion into 44 words, grouped into 11 round keys
  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
        t = t ^ {RCON[i/4 - 1], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++)
      model_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input bit s, input logic st, input logic [127:0] k, input logic rdy);
    if (s) begin
      if1.start = st; if1.key_in = k; if1.rk_ready = rdy;
    end else begin
      if0.start = st; if0.key_in = k; if0.rk_ready = rdy;
    end
  endtask

  // One complete run: start, wait for key 10, drain 11 keys with random
  // ready, then check the done pulse. poke=1 fires spurious starts that
  // must be ignored. model_rk must already hold the expected schedule.
  task automatic run_key(input bit s, input logic [127:0] kin, input int ready_pct, input bit poke);
    int lat;
    int hs;
    int cyc;
    bit rdy;
    bit prev_stall;
    logic [127:0] prev_rk;

    exp_q.delete();
    for (int k = 10; k >= 0; k--) exp_q.push_back(model_rk[k]);
    sel = s;

    @(negedge clk);
    drive(s, 1'b1, kin, 1'b0);
    @(negedge clk);
    drive(s, 1'b0, kin, 1'b0);
    lat = 1;
    while (!o_valid && lat < 40) begin
      check("busy_fwd", o_busy, 1);
      drive(s, poke ? 1'($urandom_range(0, 1)) : 1'b0, rand128(), 1'b0);
      @(negedge clk);
      lat++;
    end
    check(s ? "latency_skip" : "latency_fwd", lat, s ? 1 : 11);

    hs = 0; cyc = 0; prev_stall = 1'b0; prev_rk = '0;
    while (hs < 11 && cyc < 400) begin
      check("rk_valid", o_valid, 1);
      check("busy_emit", o_busy, 1);
      check("rk_idx", o_idx, 10 - hs);
      check("rk_value", o_rk, exp_q[0]);
      if (prev_stall) check("rk_hold", o_rk, prev_rk);
      if (hs <= 10) got_rk[10 - hs] = o_rk;
      rdy = ($urandom_range(0, 99) < ready_pct);
      drive(s, poke ? 1'($urandom_range(0, 1)) : 1'b0, rand128(), rdy);
      if (rdy) begin
        void'(exp_q.pop_front());
        hs++;
      end
      prev_stall = !rdy;
      prev_rk    = o_rk;
      @(negedge clk);
      cyc++;
    end
    check("handshakes", hs, 11);

    check("done_pulse", o_done, 1);
    check("valid_after", o_valid, 0);
    check("busy_after", o_busy, 0);
    // A start on the done cycle must not launch a new run
    drive(s, poke, rand128(), 1'b0);
    @(negedge clk);
    drive(s, 1'b0, kin, 1'b0);
    check("done_once", o_done, 0);
    check("idle_busy", o_busy, 0);
    check("idle_valid", o_valid, 0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] k;
    int n;

    rst = 1'b1;
    sel = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", if0.busy, 0);
    check("rst_valid", if0.rk_valid, 0);
    check("rst_done", if0.done, 0);
    check("rst_rk", if0.rk, 0);
    check("rst_idx", if0.rk_idx, 0);
    check("rst_skip_valid", if1.rk_valid, 0);
    check("rst_skip_rk", if1.rk, 0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key, full throughput
    compute_model(FIPS_KEY);
    check("model_rk10", model_rk[10], FIPS_RK10);
    run_key(1'b0, FIPS_KEY, 100, 1'b0);
    check("fips_rk10", got_rk[10], FIPS_RK10);
    check("fips_rk9", got_rk[9], FIPS_RK9);
    check("fips_rk1", got_rk[1], FIPS_RK1);
    check("fips_rk0", got_rk[0], FIPS_KEY);

    // Random keys with random backpressure
    for (int i = 0; i < 4; i++) begin
      k = rand128();
      compute_model(k);
      run_key(1'b0, k, 50, 1'b0);
    end

    // Forward pass skipped: start from round key 10
    compute_model(FIPS_KEY);
    run_key(1'b1, FIPS_RK10, 100, 1'b0);
    check("skip_rk0", got_rk[0], FIPS_KEY);
    for (int i = 0; i < 2; i++) begin
      k = rand128();
      compute_model(k);
      run_key(1'b1, model_rk[10], 60, 1'b0);
    end

    // Reset in the middle of emitting, at idx 5
    sel = 1'b0;
    compute_model(FIPS_KEY);
    @(negedge clk);
    drive(1'b0, 1'b1, FIPS_KEY, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, FIPS_KEY, 1'b1);
    n = 0;
    while (!(o_valid && o_idx == 4'd5) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx5", o_idx, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", o_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_rk", o_rk, 0);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", o_valid, 0);
    drive(1'b0, 1'b0, FIPS_KEY, 1'b0);
    run_key(1'b0, FIPS_KEY, 100, 1'b0);
    check("rerun_rk10", got_rk[10], FIPS_RK10);
    check("rerun_rk0", got_rk[0], FIPS_KEY);

    // Spurious starts during FWD, EMIT and the done cycle
    for (int i = 0; i < 2; i++) begin
      k = rand128();
      compute_model(k);
      run_key(1'b0, k, 70, 1'b1);
    end
    compute_model(FIPS_KEY);
    run_key(1'b1, FIPS_RK10, 70, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
